popcount_stream: RTL and testbench
==================================

POPCOUNT_STREAM -- requirements
Module: popcount_stream

Interface
REQ-001 SHALL have parameter VWIDTH, default 16, input vector width (>=1).
REQ-002 SHALL have parameter PIPELINE, default 32'h5, bit i registers tree level i (level 0 = leaf pairs); NLEV = max(1,$clog2(VWIDTH)) levels.
REQ-003 SHALL have parameter FRAME_MODE, default 0: 0 = one result per beat, 1 = one result per frame.
REQ-004 SHALL have parameter AWIDTH, default 16, accumulator/result width (>= $clog2(VWIDTH+1)).
REQ-005 SHALL have derived parameter CWIDTH = $clog2(VWIDTH+1), treated as localparam.
REQ-006 clk  in  1  clock.
REQ-007 rst  in  1  reset, asynchronous, active-high.
REQ-008 in_valid  in  1  input beat valid.
REQ-009 in_ready  out  1  input beat accepted when in_valid && in_ready.
REQ-010 in_vector  in  VWIDTH  data to count.
REQ-011 in_mask  in  VWIDTH  1 = bit participates; 0 = ignored.
REQ-012 in_zeros  in  1  0 = count ones, 1 = count zeros (sampled per beat).
REQ-013 in_last  in  1  last beat of frame (ignored when FRAME_MODE=0).
REQ-014 out_valid  out  1  result valid.
REQ-015 out_ready  in  1  downstream accepts result.
REQ-016 out_count  out  AWIDTH  count result.
REQ-017 out_sat  out  1  result saturated.

Function
REQ-018 Beat count SHALL equal the number of i with in_mask[i]=1 and in_vector[i] = ~in_zeros.
REQ-019 Counting SHALL use a balanced binary adder tree; level i registered iff PIPELINE[i]=1, else combinational; PIPELINE bits >= NLEV ignored.
REQ-020 A fixed output register SHALL follow the tree; latency in_accept->out_valid = popcount(PIPELINE[NLEV-1:0]) + 1 cycles.
REQ-021 Each registered stage SHALL carry a valid bit (and in_last) alongside data.
REQ-022 Stall: enable = !out_valid || out_ready; all stages and accumulator advance only when enable=1; in_ready = enable.
REQ-023 No beat SHALL be dropped or duplicated under any out_ready pattern; bubbles allowed to propagate.
REQ-024 FRAME_MODE=0: each accepted beat SHALL produce exactly one result, out_count = zero-extended beat count.
REQ-025 FRAME_MODE=1: accumulator SHALL add each beat count; result emitted only on in_last beat = sum of frame, then accumulator cleared same cycle; next frame starts from 0.
REQ-026 Frame of one beat (in_last on first beat) SHALL yield that beat's count.
REQ-027 Accumulator SHALL saturate at 2^AWIDTH-1; out_sat=1 if any saturation in that frame (or beat); flag clears with frame.
REQ-028 in_zeros and in_mask MAY change every beat, including mid-frame.
REQ-029 out_count/out_sat SHALL hold stable while out_valid && !out_ready.

Reset
REQ-030 On rst: out_valid=0, out_count=0, out_sat=0, all stage valids=0, accumulator=0; in_ready=1 one cycle after rst deasserts.
REQ-031 Reset mid-frame SHALL discard the partial frame and all in-flight beats.

Structure
REQ-032 Package popcount_pkg SHALL hold count-mode typedef (CNT_ONES/CNT_ZEROS) and width functions (CWIDTH, stage count).
REQ-033 Sub-module popcount_tree (VWIDTH, PIPELINE; clk, rst, en, valid/last sideband) SHALL implement REQ-018..021; popcount_stream adds handshake, accumulator, saturation.

Verification
REQ-034 VWIDTH=8, PIPELINE=3'b011, mask=FF, zeros=0, vector=8'hB5 -> out_count=5 exactly 3 cycles after accept.
REQ-035 Same, zeros=1, mask=8'h0F, vector=8'h03 -> out_count=2.
REQ-036 FRAME_MODE=1, beats 8'hFF, 8'h01, 8'h00(last) -> single result 9, then next frame 8'h0F(last) -> 4.
REQ-037 AWIDTH=4, FRAME_MODE=1, VWIDTH=8, beats FF, FF, FF(last) -> out_count=15, out_sat=1; next frame 01(last) -> 1, out_sat=0.
REQ-038 Streaming 100 random beats, out_ready random 50% -> scoreboard order and values match, no loss; in_ready=0 only while out_valid && !out_ready.
REQ-039 rst asserted after 2 beats of a 3-beat frame -> out_valid=0 immediately; new frame 8'h01(last) -> result 1.

Source files
------------

// File: rtl/popcount_pkg.sv
// Shared types and elaboration-time width helpers for the popcount stream.
package popcount_pkg;

  typedef enum logic {
    CNT_ONES  = 1'b0,
    CNT_ZEROS = 1'b1
  } cnt_mode_t;

  // Bits needed to hold a count of 0..vwidth.
  function automatic int cnt_width(input int vwidth);
    return $clog2(vwidth + 1);
  endfunction

  function automatic int tree_levels(input int vwidth);
    return (vwidth <= 2) ? 1 : $clog2(vwidth);
  endfunction

  function automatic int reg_stages(input logic [31:0] pipeline, input int nlev);
    int n;
    n = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (int'(i) < nlev && pipeline[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/popcount_tree.sv
// Balanced adder tree over qualified bits; each level optionally registered
// with valid/last sideband travelling alongside the partial sums.
module popcount_tree
  import popcount_pkg::*;
#(
  parameter int          VWIDTH   = 16,
  parameter logic [31:0] PIPELINE = 32'h5,
  localparam int         CWIDTH   = cnt_width(VWIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_valid,
  input  logic              in_last,
  input  logic [VWIDTH-1:0] in_bits,
  output logic              out_valid,
  output logic              out_last,
  output logic [CWIDTH-1:0] out_count
);

  localparam int NLEV = tree_levels(VWIDTH);
  localparam int PW   = 2 ** NLEV;

  logic [PW-1:0] leaves;
  assign leaves = PW'(in_bits);

  for (genvar l = 0; l < NLEV; l++) begin : g_lvl
    localparam int N = PW >> (l + 1);
    logic [N-1:0][CWIDTH-1:0] sum;
    logic [N-1:0][CWIDTH-1:0] q;
    logic                     v_in, last_in, v_q, last_q;

    if (l == 0) begin : g_leaf
      for (genvar j = 0; j < N; j++) begin : g_pair
        assign sum[j] = CWIDTH'(leaves[2*j]) + CWIDTH'(leaves[2*j+1]);
      end
      assign v_in    = in_valid;
      assign last_in = in_last;
    end else begin : g_node
      for (genvar j = 0; j < N; j++) begin : g_pair
        assign sum[j] = g_lvl[l-1].q[2*j] + g_lvl[l-1].q[2*j+1];
      end
      assign v_in    = g_lvl[l-1].v_q;
      assign last_in = g_lvl[l-1].last_q;
    end

    if (PIPELINE[l]) begin : g_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q      <= '0;
          v_q    <= 1'b0;
          last_q <= 1'b0;
        end else if (en) begin
          q      <= sum;
          v_q    <= v_in;
          last_q <= last_in;
        end
      end
    end else begin : g_comb
      assign q      = sum;
      assign v_q    = v_in;
      assign last_q = last_in;
    end
  end

  assign out_count = g_lvl[NLEV-1].q[0];
  assign out_valid = g_lvl[NLEV-1].v_q;
  assign out_last  = g_lvl[NLEV-1].last_q;

endmodule

// File: rtl/popcount_stream.sv
// Streaming masked popcount with backpressure; per-beat or per-frame
// saturating accumulation behind a fixed output register.
module popcount_stream
  import popcount_pkg::*;
#(
  parameter int          VWIDTH     = 16,
  parameter logic [31:0] PIPELINE   = 32'h5,
  parameter int          FRAME_MODE = 0,
  parameter int          AWIDTH     = 16,
  localparam int         CWIDTH     = cnt_width(VWIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [VWIDTH-1:0] in_vector,
  input  logic [VWIDTH-1:0] in_mask,
  input  logic              in_zeros,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [AWIDTH-1:0] out_count,
  output logic              out_sat
);

  cnt_mode_t         mode;
  logic [VWIDTH-1:0] qual_bits;
  logic              enable;
  logic              t_valid, t_last;
  logic [CWIDTH-1:0] t_count;
  logic [AWIDTH-1:0] acc, acc_base, sat_sum;
  logic              acc_sat, frame_sat, ovf, frame_end;
  logic [AWIDTH:0]   sum_w;

  assign mode      = cnt_mode_t'(in_zeros);
  assign qual_bits = in_mask & ((mode == CNT_ZEROS) ? ~in_vector : in_vector);

  // Whole pipeline freezes only when a result is held for downstream.
  assign enable   = !out_valid || out_ready;
  assign in_ready = enable;

  popcount_tree #(
    .VWIDTH  (VWIDTH),
    .PIPELINE(PIPELINE)
  ) u_tree (
    .clk      (clk),
    .rst      (rst),
    .en       (enable),
    .in_valid (in_valid && enable),
    .in_last  (in_last),
    .in_bits  (qual_bits),
    .out_valid(t_valid),
    .out_last (t_last),
    .out_count(t_count)
  );

  assign acc_base  = (FRAME_MODE != 0) ? acc : '0;
  assign sum_w     = {1'b0, acc_base} + (AWIDTH+1)'(t_count);
  assign ovf       = sum_w[AWIDTH];
  assign sat_sum   = ovf ? '1 : sum_w[AWIDTH-1:0];
  assign frame_sat = ((FRAME_MODE != 0) && acc_sat) || ovf;
  assign frame_end = (FRAME_MODE == 0) || t_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_count <= '0;
      out_sat   <= 1'b0;
      acc       <= '0;
      acc_sat   <= 1'b0;
    end else if (enable) begin
      if (t_valid && frame_end) begin
        out_valid <= 1'b1;
        out_count <= sat_sum;
        out_sat   <= frame_sat;
        acc       <= '0;
        acc_sat   <= 1'b0;
      end else begin
        out_valid <= 1'b0;
        if (t_valid) begin
          acc     <= sat_sum;
          acc_sat <= frame_sat;
        end
      end
    end
  end

endmodule

// File: tb/tb_popcount_stream.sv
// Two instances (per-beat and per-frame with narrow accumulator) checked
// against a queue-based reference model under random backpressure.
module tb_popcount_stream;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       a_in_valid, a_in_ready, a_in_zeros, a_in_last, a_out_valid, a_out_ready, a_out_sat;
  logic [7:0] a_in_vector, a_in_mask;
  logic [15:0] a_out_count;

  logic       b_in_valid, b_in_ready, b_in_zeros, b_in_last, b_out_valid, b_out_ready, b_out_sat;
  logic [7:0] b_in_vector, b_in_mask;
  logic [3:0] b_out_count;

  popcount_stream #(.VWIDTH(8), .PIPELINE(32'h3), .FRAME_MODE(0), .AWIDTH(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_vector(a_in_vector), .in_mask(a_in_mask), .in_zeros(a_in_zeros), .in_last(a_in_last),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_count(a_out_count), .out_sat(a_out_sat)
  );

  popcount_stream #(.VWIDTH(8), .PIPELINE(32'h5), .FRAME_MODE(1), .AWIDTH(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_vector(b_in_vector), .in_mask(b_in_mask), .in_zeros(b_in_zeros), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_count(b_out_count), .out_sat(b_out_sat)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_count(input logic [7:0] v, input logic [7:0] m, input logic z);
    int n;
    n = 0;
    for (int unsigned i = 0; i < 8; i++)
      if (m[i] && (v[i] == !z)) n++;
    return n;
  endfunction

  int qa[$];
  int qb_cnt[$];
  int qb_sat[$];
  int b_sum;
  int a_rdy_mode, b_rdy_mode;  // 0 = always ready, 1 = random, 2 = never

  initial begin
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      a_out_ready = (a_rdy_mode == 1) ? 1'($urandom_range(1, 0)) : (a_rdy_mode == 0);
      b_out_ready = (b_rdy_mode == 1) ? 1'($urandom_range(1, 0)) : (b_rdy_mode == 0);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("a_in_ready", a_in_ready, !(a_out_valid && !a_out_ready));
      if (a_in_valid && a_in_ready) qa.push_back(ref_count(a_in_vector, a_in_mask, a_in_zeros));
      if (a_out_valid) begin
        if (qa.size() == 0) check("a_extra", a_out_valid, 0);
        else begin
          check("a_count", a_out_count, qa[0]);
          check("a_sat", a_out_sat, 0);
          if (a_out_ready) void'(qa.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("b_in_ready", b_in_ready, !(b_out_valid && !b_out_ready));
      if (b_in_valid && b_in_ready) begin
        b_sum += ref_count(b_in_vector, b_in_mask, b_in_zeros);
        if (b_in_last) begin
          qb_cnt.push_back((b_sum > 15) ? 15 : b_sum);
          qb_sat.push_back(b_sum > 15);
          b_sum = 0;
        end
      end
      if (b_out_valid) begin
        if (qb_cnt.size() == 0) check("b_extra", b_out_valid, 0);
        else begin
          check("b_count", b_out_count, qb_cnt[0]);
          check("b_sat", b_out_sat, qb_sat[0]);
          if (b_out_ready) begin
            void'(qb_cnt.pop_front());
            void'(qb_sat.pop_front());
          end
        end
      end
    end
  end

  // Tasks are entered and left at posedge+1 so inputs never move near a sample.
  task automatic a_send(input logic [7:0] v, input logic [7:0] m, input logic z);
    bit ok;
    ok = 0;
    a_in_vector = v; a_in_mask = m; a_in_zeros = z; a_in_last = 1'b0; a_in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (a_in_ready) begin ok = 1; break; end
    end
    if (!ok) check("a_send_timeout", a_in_ready, 1);
    @(posedge clk); #1;
    a_in_valid = 1'b0;
  endtask

  task automatic b_send(input logic [7:0] v, input logic [7:0] m, input logic z, input logic l);
    bit ok;
    ok = 0;
    b_in_vector = v; b_in_mask = m; b_in_zeros = z; b_in_last = l; b_in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (b_in_ready) begin ok = 1; break; end
    end
    if (!ok) check("b_send_timeout", b_in_ready, 1);
    @(posedge clk); #1;
    b_in_valid = 1'b0;
  endtask

  task automatic a_expect(input string tag, input int exp);
    bit seen;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (a_out_valid) begin seen = 1; check(tag, a_out_count, exp); break; end
    end
    if (!seen) check({tag, "_timeout"}, a_out_valid, 1);
    @(posedge clk); #1;
  endtask

  task automatic b_expect(input string tag, input int exp, input logic exp_sat);
    bit seen;
    seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (b_out_valid) begin
        seen = 1;
        check(tag, b_out_count, exp);
        check({tag, "_sat"}, b_out_sat, exp_sat);
        break;
      end
    end
    if (!seen) check({tag, "_timeout"}, b_out_valid, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    bit seen;
    a_rdy_mode = 0; b_rdy_mode = 0; b_sum = 0;
    a_in_valid = 0; a_in_vector = '0; a_in_mask = '0; a_in_zeros = 0; a_in_last = 0;
    b_in_valid = 0; b_in_vector = '0; b_in_mask = '0; b_in_zeros = 0; b_in_last = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_a_valid", a_out_valid, 0);
    check("rst_a_count", a_out_count, 0);
    check("rst_a_sat", a_out_sat, 0);
    check("rst_b_valid", b_out_valid, 0);
    check("rst_b_count", b_out_count, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rdy_after_rst", a_in_ready, 1);
    @(posedge clk); #1;

    // Latency and count of a single beat through a two-register tree.
    a_in_vector = 8'hB5; a_in_mask = 8'hFF; a_in_zeros = 0; a_in_valid = 1;
    @(negedge clk);
    check("lat_accept", a_in_ready, 1);
    n = 0; seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1; a_in_valid = 0;
      @(negedge clk); n++;
      if (a_out_valid) begin seen = 1; break; end
    end
    check("lat_cycles", n, 3);
    check("lat_count", a_out_count, 5);
    @(posedge clk); #1;

    a_send(8'h03, 8'h0F, 1'b1);
    a_expect("zeros_mask", 2);

    b_send(8'hFF, 8'hFF, 0, 0); b_send(8'h01, 8'hFF, 0, 0); b_send(8'h00, 8'hFF, 0, 1);
    b_expect("frame3", 9, 0);
    b_send(8'h0F, 8'hFF, 0, 1);
    b_expect("frame1", 4, 0);

    b_send(8'hFF, 8'hFF, 0, 0); b_send(8'hFF, 8'hFF, 0, 0); b_send(8'hFF, 8'hFF, 0, 1);
    b_expect("sat_frame", 15, 1);
    b_send(8'h01, 8'hFF, 0, 1);
    b_expect("after_sat", 1, 0);

    // Reset with a finished result held and a partial frame in flight.
    b_rdy_mode = 2;
    b_send(8'h07, 8'hFF, 0, 1);
    b_send(8'hFF, 8'hFF, 0, 0);
    b_send(8'hFF, 8'hFF, 0, 0);
    rst = 1'b1;
    #1;
    check("midrst_valid", b_out_valid, 0);
    check("midrst_count", b_out_count, 0);
    check("midrst_sat", b_out_sat, 0);
    qa.delete(); qb_cnt.delete(); qb_sat.delete(); b_sum = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    b_rdy_mode = 0;
    @(posedge clk); #1;
    b_send(8'h01, 8'hFF, 0, 1);
    b_expect("post_rst", 1, 0);

    a_rdy_mode = 1;
    for (int i = 0; i < 100; i++) begin
      a_send(8'($urandom), 8'($urandom), 1'($urandom));
      if ($urandom_range(3, 0) == 0) begin @(posedge clk); #1; end
    end

    b_rdy_mode = 1;
    for (int i = 0; i < 60; i++)
      b_send(8'($urandom), 8'($urandom), 1'($urandom), (i == 59) || ($urandom_range(3, 0) == 0));

    a_rdy_mode = 0; b_rdy_mode = 0;
    for (int i = 0; i < 100; i++) begin
      if (qa.size() == 0 && qb_cnt.size() == 0) break;
      @(posedge clk); #1;
    end
    check("a_drain", qa.size(), 0);
    check("b_drain", qb_cnt.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
